// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: funct codes, FSM states, widths.
// Also holds the magnitude helper used when latching signed operands.
package mdu_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int MDU_ITERS  = 32;

  localparam logic [5:0] OP_MULT  = 6'b011000;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_DIV   = 6'b011010;
  localparam logic [5:0] OP_DIVU  = 6'b011011;
  localparam logic [5:0] OP_MTHI  = 6'b010001;
  localparam logic [5:0] OP_MTLO  = 6'b010011;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } mdu_state_e;

  // The magnitude of 0x80000000 is 0x80000000 when read as unsigned, which is what the datapath needs.
  function automatic logic [DATA_WIDTH-1:0] mdu_mag(input logic [DATA_WIDTH-1:0] v,
                                                    input logic is_signed);
    return (is_signed && v[DATA_WIDTH-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One radix-2 iteration of the MDU datapath: shift-add multiply or restoring divide.
// For divide, acc holds {remainder, quotient}; for multiply, {partial product, multiplier}.
module mdu_iter_step
  import mdu_pkg::*;
(
  input  logic [2*DATA_WIDTH-1:0] acc_i,
  input  logic [DATA_WIDTH-1:0]   operand_i,
  input  logic                    is_div_i,
  output logic [2*DATA_WIDTH-1:0] acc_o
);

  logic [DATA_WIDTH:0]   mul_sum;
  logic [2*DATA_WIDTH:0] div_shift;
  logic [DATA_WIDTH:0]   div_trial;

  // Trial result bit DATA_WIDTH acts as the sign of the 33-bit remainder subtraction.
  always_comb begin
    mul_sum   = {1'b0, acc_i[2*DATA_WIDTH-1:DATA_WIDTH]}
              + (acc_i[0] ? {1'b0, operand_i} : {(DATA_WIDTH+1){1'b0}});
    div_shift = {acc_i, 1'b0};
    div_trial = div_shift[2*DATA_WIDTH:DATA_WIDTH] - {1'b0, operand_i};
    acc_o     = {mul_sum, acc_i[DATA_WIDTH-1:1]};
    if (is_div_i) begin
      if (!div_trial[DATA_WIDTH]) begin
        acc_o = {div_trial[DATA_WIDTH-1:0], div_shift[DATA_WIDTH-1:1], 1'b1};
      end else begin
        acc_o = div_shift[2*DATA_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Iterative multiply/divide controller holding the HI/LO registers for the EX stage.
// Define MDU_FAST_MULT_EN to compute multiplies in a single cycle; divides stay iterative.
module mdu_ctrl
  import mdu_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [5:0]            operation,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic [DATA_WIDTH-1:0] data_b,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  mdu_state_e              state_q;
  logic [5:0]              cnt_q;
  logic [2*DATA_WIDTH-1:0] acc_q;
  logic [DATA_WIDTH-1:0]   opnd_q;
  logic                    is_div_q;
  logic                    neg_res_q;
  logic                    neg_rem_q;
  logic [DATA_WIDTH-1:0]   hi_q;
  logic [DATA_WIDTH-1:0]   lo_q;
  logic                    busy_q;
  logic                    done_q;

  logic [2*DATA_WIDTH-1:0] acc_d;
  logic [2*DATA_WIDTH-1:0] prod_fix;
  logic [DATA_WIDTH-1:0]   quot_fix;
  logic [DATA_WIDTH-1:0]   rem_fix;
  logic [DATA_WIDTH-1:0]   a_mag;
  logic [DATA_WIDTH-1:0]   b_mag;
  logic                    is_mul_req;
  logic                    is_div_req;
  logic                    is_signed_req;

  always_comb begin
    is_mul_req    = (operation == OP_MULT) || (operation == OP_MULTU);
    is_div_req    = (operation == OP_DIV)  || (operation == OP_DIVU);
    is_signed_req = (operation == OP_MULT) || (operation == OP_DIV);
    a_mag         = mdu_mag(data_a, is_signed_req);
    b_mag         = mdu_mag(data_b, is_signed_req);
    prod_fix      = neg_res_q ? -acc_q : acc_q;
    quot_fix      = neg_res_q ? -acc_q[DATA_WIDTH-1:0] : acc_q[DATA_WIDTH-1:0];
    rem_fix       = neg_rem_q ? -acc_q[2*DATA_WIDTH-1:DATA_WIDTH]
                              : acc_q[2*DATA_WIDTH-1:DATA_WIDTH];
  end

`ifdef MDU_FAST_MULT_EN
  logic [2*DATA_WIDTH-1:0] fast_prod;
  assign fast_prod = {{DATA_WIDTH{1'b0}}, a_mag} * {{DATA_WIDTH{1'b0}}, b_mag};
`endif

  mdu_iter_step u_step (
    .acc_i     (acc_q),
    .operand_i (opnd_q),
    .is_div_i  (is_div_q),
    .acc_o     (acc_d)
  );

  // Divide by zero keeps the quotient unnegated so LO reads all ones for DIV as well as DIVU.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (flush) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start && (is_mul_req || is_div_req)) begin
              is_div_q  <= is_div_req;
              neg_res_q <= is_signed_req && (data_a[DATA_WIDTH-1] ^ data_b[DATA_WIDTH-1])
                           && (is_mul_req || (data_b != '0));
              neg_rem_q <= is_signed_req && data_a[DATA_WIDTH-1];
              opnd_q    <= is_div_req ? b_mag : a_mag;
              acc_q     <= {{DATA_WIDTH{1'b0}}, (is_div_req ? a_mag : b_mag)};
              cnt_q     <= '0;
              busy_q    <= 1'b1;
`ifdef MDU_FAST_MULT_EN
              if (is_mul_req) begin
                acc_q   <= fast_prod;
                state_q <= FIX;
              end else begin
                state_q <= CALC;
              end
`else
              state_q   <= CALC;
`endif
            end else if (start && (operation == OP_MTHI)) begin
              hi_q <= data_a;
            end else if (start && (operation == OP_MTLO)) begin
              lo_q <= data_a;
            end
          end
          CALC: begin
            acc_q <= acc_d;
            if (cnt_q == 6'(MDU_ITERS - 1)) begin
              state_q <= FIX;
            end else begin
              cnt_q <= cnt_q + 6'd1;
            end
          end
          FIX: begin
            if (is_div_q) begin
              hi_q <= rem_fix;
              lo_q <= quot_fix;
            end else begin
              hi_q <= prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
              lo_q <= prod_fix[DATA_WIDTH-1:0];
            end
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: arithmetic reference model compared every cycle,
// plus directed vectors with hand-computed HI/LO values and latency checks.
module tb_mdu_ctrl;
  import mdu_pkg::*;

`ifdef MDU_FAST_MULT_EN
  localparam int MULT_LAT = 1;
`else
  localparam int MULT_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [5:0]  operation;
  logic [31:0] data_a;
  logic [31:0] data_b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int vectors     = 0;
  int miscompares = 0;
  bit checkEn     = 1'b0;

  logic        m_busy;
  logic        m_done;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [63:0] m_res;
  int          m_left;

  always #5 clk = ~clk;

  mdu_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .operation (operation),
    .data_a    (data_a),
    .data_b    (data_b),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  // Architectural result {HI, LO} computed with plain integer arithmetic.
  function automatic logic [63:0] refResult(input logic [5:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    case (op)
      OP_MULT:  p = sa * sb;
      OP_MULTU: p = {32'b0, a} * {32'b0, b};
      OP_DIV: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      OP_DIVU: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else p = {a % b, a / b};
      end
      default: p = '0;
    endcase
    return p;
  endfunction

  // Timing model: an accepted operation completes a fixed number of edges later.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_res  <= '0;
      m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (flush) begin
        m_busy <= 1'b0;
        m_left <= 0;
      end else if (m_left == 1) begin
        m_hi   <= m_res[63:32];
        m_lo   <= m_res[31:0];
        m_done <= 1'b1;
        m_busy <= 1'b0;
        m_left <= 0;
      end else if (m_left > 1) begin
        m_left <= m_left - 1;
      end else if (start) begin
        case (operation)
          OP_MULT, OP_MULTU: begin
            m_res  <= refResult(operation, data_a, data_b);
            m_left <= MULT_LAT;
            m_busy <= 1'b1;
          end
          OP_DIV, OP_DIVU: begin
            m_res  <= refResult(operation, data_a, data_b);
            m_left <= DIV_LAT;
            m_busy <= 1'b1;
          end
          OP_MTHI: m_hi <= data_a;
          OP_MTLO: m_lo <= data_a;
          default: ;
        endcase
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model busy", 64'(busy), 64'(m_busy));
      checkOutput("model done", 64'(done), 64'(m_done));
      checkOutput("model hi", 64'(hi), 64'(m_hi));
      checkOutput("model lo", 64'(lo), 64'(m_lo));
    end
  end

  task automatic applyStimulus(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    start     = 1'b1;
    operation = op;
    data_a    = a;
    data_b    = b;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic waitDone(input int budget, output int cycles, output int busyCycles);
    cycles     = 0;
    busyCycles = busy ? 1 : 0;
    while (cycles < budget) begin
      @(posedge clk); #1;
      cycles++;
      if (busy) busyCycles++;
      if (done) break;
    end
    if (!done) checkOutput("done timeout", 64'(done), 64'd1);
  endtask

  task automatic runOp(input string name, input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int lat, input logic [31:0] expHi,
                       input logic [31:0] expLo);
    int cycles, busyCycles;
    applyStimulus(op, a, b);
    waitDone(100, cycles, busyCycles);
    checkOutput({name, " latency"}, 64'(cycles), 64'(lat));
    checkOutput({name, " busy cycles"}, 64'(busyCycles), 64'(lat));
    checkOutput({name, " hi"}, 64'(hi), 64'(expHi));
    checkOutput({name, " lo"}, 64'(lo), 64'(expLo));
  endtask

  initial begin
    int cycles, busyCycles, doneSeen, busySeen;
    reset_n   = 1'b0;
    start     = 1'b0;
    flush     = 1'b0;
    operation = '0;
    data_a    = '0;
    data_b    = '0;
    repeat (2) @(negedge clk);
    checkEn = 1'b1;
    checkOutput("reset hi", 64'(hi), 64'd0);
    checkOutput("reset lo", 64'(lo), 64'd0);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    runOp("multu max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULT_LAT, 32'hFFFF_FFFE, 32'h0000_0001);
    runOp("mult -7*3", OP_MULT, 32'hFFFF_FFF9, 32'd3, MULT_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    runOp("mult minint sq", OP_MULT, 32'h8000_0000, 32'h8000_0000, MULT_LAT, 32'h4000_0000, 32'h0);
    runOp("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, DIV_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    runOp("div 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, DIV_LAT, 32'h0000_0001, 32'hFFFF_FFFD);
    runOp("divu by zero", OP_DIVU, 32'd100, 32'd0, DIV_LAT, 32'd100, 32'hFFFF_FFFF);
    runOp("div by zero neg", OP_DIV, 32'hFFFF_FFF0, 32'd0, DIV_LAT, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
    runOp("div overflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT, 32'h0, 32'h8000_0000);

    // MTHI then MTLO back to back; busy must never rise.
    busySeen = 0;
    @(posedge clk); #1;
    start = 1'b1; operation = OP_MTHI; data_a = 32'h1234;
    @(posedge clk); #1;
    if (busy) busySeen++;
    checkOutput("mthi visible", 64'(hi), 64'h1234);
    operation = OP_MTLO; data_a = 32'h5678;
    @(posedge clk); #1;
    if (busy) busySeen++;
    start = 1'b0;
    @(posedge clk); #1;
    if (busy) busySeen++;
    checkOutput("mt busy seen", 64'(busySeen), 64'd0);
    checkOutput("mt hi", 64'(hi), 64'h1234);
    checkOutput("mt lo", 64'(lo), 64'h5678);

    // A start while busy is dropped, not queued.
    applyStimulus(OP_DIVU, 32'd50, 32'd7);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1; operation = OP_MTHI; data_a = 32'hDEAD;
    @(posedge clk); #1;
    start = 1'b0;
    waitDone(100, cycles, busyCycles);
    @(posedge clk); #1;
    checkOutput("busy-start hi", 64'(hi), 64'd1);
    checkOutput("busy-start lo", 64'(lo), 64'd7);

    // Flush mid-divide leaves HI/LO and never signals done.
    applyStimulus(OP_DIVU, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checkOutput("flush busy", 64'(busy), 64'd0);
    doneSeen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) doneSeen++;
    end
    checkOutput("flush no done", 64'(doneSeen), 64'd0);
    checkOutput("flush hi", 64'(hi), 64'd1);
    checkOutput("flush lo", 64'(lo), 64'd7);

    // Flush beats a simultaneous start.
    @(posedge clk); #1;
    flush = 1'b1; start = 1'b1; operation = OP_MTHI; data_a = 32'hBEEF;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    checkOutput("flush vs start hi", 64'(hi), 64'd1);

    // Asynchronous reset mid-operation clears HI/LO immediately.
    applyStimulus(OP_DIVU, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("midreset hi", 64'(hi), 64'd0);
    checkOutput("midreset lo", 64'(lo), 64'd0);
    checkOutput("midreset busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    runOp("multu after reset", OP_MULTU, 32'h0001_0000, 32'h0001_0000, MULT_LAT, 32'd1, 32'd0);

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
